hdmi_video_timing_gen: RTL and testbench

- Downstream consumer of the hdmi_interface AXI4-Lite register block. Takes its timing/control register values and generates raster timing for the HDMI encoder: hsync, vsync, data-enable, pixel coordinates and frame/line strobes.
- Config is double-buffered. New values are applied only at a frame boundary (or while disabled), so software writes never tear a frame.

---
 rtl/hdmi_video_timing_gen.sv | 182 ++++++++++++++++++
 tb/tb_hdmi_video_timing_gen.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_video_timing_gen.sv
// rtl/hdmi_video_timing_gen.sv - double-buffered raster timing generator (optional HDMI_TIMING_TEST_PATTERN_EN adds rgb_out)
module hdmi_video_timing_gen #(
    parameter int CNT_W = 12
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             cfg_enable,
    input  logic             cfg_update,
    input  logic [CNT_W-1:0] cfg_h_active,
    input  logic [CNT_W-1:0] cfg_h_fp,
    input  logic [CNT_W-1:0] cfg_h_sync,
    input  logic [CNT_W-1:0] cfg_h_bp,
    input  logic [CNT_W-1:0] cfg_v_active,
    input  logic [CNT_W-1:0] cfg_v_fp,
    input  logic [CNT_W-1:0] cfg_v_sync,
    input  logic [CNT_W-1:0] cfg_v_bp,
    input  logic             cfg_hsync_pol,
    input  logic             cfg_vsync_pol,
    output logic             hsync,
    output logic             vsync,
    output logic             de,
    output logic [CNT_W-1:0] pix_x,
    output logic [CNT_W-1:0] pix_y,
    output logic             line_start,
    output logic             frame_start,
`ifdef HDMI_TIMING_TEST_PATTERN_EN
    output logic [23:0]      rgb_out,
`endif
    output logic             cfg_pending
);

    localparam int TW = CNT_W + 2;

    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] sh_ha, sh_hfp, sh_hs, sh_hbp, sh_va, sh_vfp, sh_vs, sh_vbp;
    logic             sh_hpol, sh_vpol;
    logic [CNT_W-1:0] st_ha, st_hfp, st_hs, st_hbp, st_va, st_vfp, st_vs, st_vbp;
    logic             st_hpol, st_vpol;
    logic             pending;
    logic [TW-1:0]    h_cnt, v_cnt;

    // Zero-width active/sync would collapse the raster, so they are clamped to one.
    function automatic logic [CNT_W-1:0] nz(input logic [CNT_W-1:0] x);
        return (x == '0) ? CNT_W'(1) : x;
    endfunction

    logic [TW-1:0] h_sync_beg, h_sync_end, h_total;
    logic [TW-1:0] v_sync_beg, v_sync_end, v_total;
    logic          h_last, v_last, run_now, load_now;
    logic          h_in_act, v_in_act, h_in_sync, v_in_sync;

    assign h_sync_beg = TW'(sh_ha) + TW'(sh_hfp);
    assign h_sync_end = h_sync_beg + TW'(sh_hs);
    assign h_total    = h_sync_end + TW'(sh_hbp);
    assign v_sync_beg = TW'(sh_va) + TW'(sh_vfp);
    assign v_sync_end = v_sync_beg + TW'(sh_vs);
    assign v_total    = v_sync_end + TW'(sh_vbp);

    assign h_last   = (h_cnt == h_total - TW'(1));
    assign v_last   = (v_cnt == v_total - TW'(1));
    assign run_now  = (state == RUN) && cfg_enable;
    // A write landing on the last pixel of the frame is applied directly, without a pending phase.
    assign load_now = ((state == IDLE) && pending) ||
                      (run_now && h_last && v_last && (pending || cfg_update));

    assign h_in_act  = (h_cnt < TW'(sh_ha));
    assign v_in_act  = (v_cnt < TW'(sh_va));
    assign h_in_sync = (h_cnt >= h_sync_beg) && (h_cnt < h_sync_end);
    assign v_in_sync = (v_cnt >= v_sync_beg) && (v_cnt < v_sync_end);

    assign cfg_pending = pending;

    // State register.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) state <= IDLE;
        else          state <= state_nxt;
    end

    // Next-state: run while enabled; dropping enable aborts immediately.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cfg_enable)  state_nxt = RUN;
            RUN:     if (!cfg_enable) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Staging capture and shadow (working set) load at frame boundary or while idle.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            pending <= 1'b0;
            sh_ha <= CNT_W'(640); sh_hfp <= CNT_W'(16); sh_hs <= CNT_W'(96); sh_hbp <= CNT_W'(48);
            sh_va <= CNT_W'(480); sh_vfp <= CNT_W'(10); sh_vs <= CNT_W'(2);  sh_vbp <= CNT_W'(33);
            sh_hpol <= 1'b1; sh_vpol <= 1'b1;
            st_ha <= CNT_W'(640); st_hfp <= CNT_W'(16); st_hs <= CNT_W'(96); st_hbp <= CNT_W'(48);
            st_va <= CNT_W'(480); st_vfp <= CNT_W'(10); st_vs <= CNT_W'(2);  st_vbp <= CNT_W'(33);
            st_hpol <= 1'b1; st_vpol <= 1'b1;
        end else begin
            if (cfg_update) begin
                st_ha <= cfg_h_active; st_hfp <= cfg_h_fp; st_hs <= cfg_h_sync; st_hbp <= cfg_h_bp;
                st_va <= cfg_v_active; st_vfp <= cfg_v_fp; st_vs <= cfg_v_sync; st_vbp <= cfg_v_bp;
                st_hpol <= cfg_hsync_pol; st_vpol <= cfg_vsync_pol;
            end
            if (load_now) begin
                sh_ha   <= nz(cfg_update ? cfg_h_active : st_ha);
                sh_hfp  <= cfg_update ? cfg_h_fp : st_hfp;
                sh_hs   <= nz(cfg_update ? cfg_h_sync : st_hs);
                sh_hbp  <= cfg_update ? cfg_h_bp : st_hbp;
                sh_va   <= nz(cfg_update ? cfg_v_active : st_va);
                sh_vfp  <= cfg_update ? cfg_v_fp : st_vfp;
                sh_vs   <= nz(cfg_update ? cfg_v_sync : st_vs);
                sh_vbp  <= cfg_update ? cfg_v_bp : st_vbp;
                sh_hpol <= cfg_update ? cfg_hsync_pol : st_hpol;
                sh_vpol <= cfg_update ? cfg_vsync_pol : st_vpol;
            end
            pending <= load_now ? 1'b0 : (pending | cfg_update);
        end
    end

    // Raster counters; held at zero whenever not running.
    always_ff @(posedge ACLK) begin
        if (!ARESETN || !run_now) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_last) begin
            h_cnt <= '0;
            v_cnt <= v_last ? '0 : v_cnt + TW'(1);
        end else begin
            h_cnt <= h_cnt + TW'(1);
        end
    end

    // Registered decode of the current counter value onto the pins.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            de <= 1'b0; hsync <= 1'b0; vsync <= 1'b0;
            line_start <= 1'b0; frame_start <= 1'b0;
            pix_x <= '0; pix_y <= '0;
        end else if (!run_now) begin
            de <= 1'b0; hsync <= ~sh_hpol; vsync <= ~sh_vpol;
            line_start <= 1'b0; frame_start <= 1'b0;
            pix_x <= '0; pix_y <= '0;
        end else begin
            de          <= h_in_act && v_in_act;
            hsync       <= h_in_sync ? sh_hpol : ~sh_hpol;
            vsync       <= v_in_sync ? sh_vpol : ~sh_vpol;
            line_start  <= (h_cnt == '0);
            frame_start <= (h_cnt == '0) && (v_cnt == '0);
            pix_x       <= (h_in_act && v_in_act) ? h_cnt[CNT_W-1:0] : '0;
            pix_y       <= (h_in_act && v_in_act) ? v_cnt[CNT_W-1:0] : '0;
        end
    end

`ifdef HDMI_TIMING_TEST_PATTERN_EN
    logic [TW+2:0] bar_idx;
    logic [2:0]    bar;
    assign bar_idx = {h_cnt, 3'b000} / (TW+3)'(sh_ha);
    assign bar     = (bar_idx >= (TW+3)'(7)) ? 3'd7 : bar_idx[2:0];

    // Eight vertical color bars across the active width, black outside active video.
    always_ff @(posedge ACLK) begin
        if (!ARESETN || !run_now || !(h_in_act && v_in_act)) begin
            rgb_out <= 24'h000000;
        end else begin
            case (bar)
                3'd0:    rgb_out <= 24'hFFFFFF;
                3'd1:    rgb_out <= 24'hFFFF00;
                3'd2:    rgb_out <= 24'h00FFFF;
                3'd3:    rgb_out <= 24'h00FF00;
                3'd4:    rgb_out <= 24'hFF00FF;
                3'd5:    rgb_out <= 24'hFF0000;
                3'd6:    rgb_out <= 24'h0000FF;
                default: rgb_out <= 24'h000000;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// tb/tb_hdmi_video_timing_gen.sv - directed-vector bench for hdmi_video_timing_gen
module tb_hdmi_video_timing_gen;

    localparam int CNT_W = 12;

    logic             ACLK, ARESETN, cfg_enable, cfg_update;
    logic [CNT_W-1:0] cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp;
    logic [CNT_W-1:0] cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp;
    logic             cfg_hsync_pol, cfg_vsync_pol;
    logic             hsync, vsync, de, line_start, frame_start, cfg_pending;
    logic [CNT_W-1:0] pix_x, pix_y;
`ifdef HDMI_TIMING_TEST_PATTERN_EN
    logic [23:0]      rgb_out;
`endif

    hdmi_video_timing_gen #(.CNT_W(CNT_W)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .cfg_enable(cfg_enable), .cfg_update(cfg_update),
        .cfg_h_active(cfg_h_active), .cfg_h_fp(cfg_h_fp), .cfg_h_sync(cfg_h_sync), .cfg_h_bp(cfg_h_bp),
        .cfg_v_active(cfg_v_active), .cfg_v_fp(cfg_v_fp), .cfg_v_sync(cfg_v_sync), .cfg_v_bp(cfg_v_bp),
        .cfg_hsync_pol(cfg_hsync_pol), .cfg_vsync_pol(cfg_vsync_pol),
        .hsync(hsync), .vsync(vsync), .de(de), .pix_x(pix_x), .pix_y(pix_y),
        .line_start(line_start), .frame_start(frame_start),
`ifdef HDMI_TIMING_TEST_PATTERN_EN
        .rgb_out(rgb_out),
`endif
        .cfg_pending(cfg_pending)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    int n_vec = 0;
    int n_err = 0;

    logic cap_de [0:63];
    logic cap_hs [0:63];
    logic cap_vs [0:63];
    int   cap_px [0:63];
    int   cap_py [0:63];
    int   cap_rgb[0:63];

    task automatic check(input string tag, input int obs, input int expv);
        n_vec++;
        if (obs != expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge ACLK);
    endtask

    task automatic set_cfg(input int ha, input int hfp, input int hs, input int hbp,
                           input int va, input int vfp, input int vs, input int vbp,
                           input logic hp, input logic vp);
        cfg_h_active = CNT_W'(ha); cfg_h_fp = CNT_W'(hfp); cfg_h_sync = CNT_W'(hs); cfg_h_bp = CNT_W'(hbp);
        cfg_v_active = CNT_W'(va); cfg_v_fp = CNT_W'(vfp); cfg_v_sync = CNT_W'(vs); cfg_v_bp = CNT_W'(vbp);
        cfg_hsync_pol = hp; cfg_vsync_pol = vp;
    endtask

    task automatic pulse_update();
        cfg_update = 1'b1;
        step(1);
        cfg_update = 1'b0;
    endtask

    // Steps until frame_start is sampled, returns the number of steps taken.
    task automatic wait_frame(input string tag, input int bound, output int steps);
        steps = 0;
        do begin
            step(1);
            steps++;
        end while (!frame_start && steps < bound);
        check(tag, frame_start, 1);
    endtask

    // Starts on a line_start sample, ends on the next one.
    task automatic measure_line(input logic act, output int len, output int de_n,
                                output int hs_n, output int hs_first);
        len = 0; de_n = 0; hs_n = 0; hs_first = -1;
        do begin
            if (de) de_n++;
            if (hsync == act) begin
                if (hs_first < 0) hs_first = len;
                hs_n++;
            end
            len++;
            step(1);
        end while (!line_start && len < 4000);
    endtask

    // Starts on a frame_start sample, ends on the next one.
    task automatic capture_frame(output int len);
        len = 0;
        do begin
            if (len < 64) begin
                cap_de[len] = de; cap_hs[len] = hsync; cap_vs[len] = vsync;
                cap_px[len] = int'(pix_x); cap_py[len] = int'(pix_y);
`ifdef HDMI_TIMING_TEST_PATTERN_EN
                cap_rgb[len] = int'(rgb_out);
`else
                cap_rgb[len] = 0;
`endif
            end
            len++;
            step(1);
        end while (!frame_start && len < 200);
    endtask

    initial begin
        int st, len, de_n, hs_n, hs_first, cnt_de, cnt_hs, cnt_vs;

        ARESETN = 1'b0; cfg_enable = 1'b0; cfg_update = 1'b0;
        set_cfg(640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
        step(3);
        check("rst_de", de, 0);
        check("rst_hsync", hsync, 0);
        check("rst_vsync", vsync, 0);
        check("rst_line_start", line_start, 0);
        check("rst_frame_start", frame_start, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pending", cfg_pending, 0);

        // default timing with active-low syncs, loaded while idle
        ARESETN = 1'b1;
        pulse_update();
        check("idle_pend_set", cfg_pending, 1);
        step(1);
        check("idle_pend_clr", cfg_pending, 0);
        step(1);
        check("idle_hs_inactive", hsync, 1);
        check("idle_vs_inactive", vsync, 1);
        cfg_enable = 1'b1;
        wait_frame("def_fs_seen", 10, st);
        check("def_en_latency", st, 2);
        check("def_fs_line_start", line_start, 1);
        measure_line(1'b0, len, de_n, hs_n, hs_first);
        check("def_line_len", len, 800);
        check("def_de_cnt", de_n, 640);
        check("def_hs_width", hs_n, 96);
        check("def_hs_start", hs_first, 656);
        check("def_l1_no_fs", frame_start, 0);
        measure_line(1'b0, len, de_n, hs_n, hs_first);
        check("def_l1_len", len, 800);
        check("def_l1_de_cnt", de_n, 640);

        // small config h 4/1/2/1, v 3/1/1/1, active-high syncs
        cfg_enable = 1'b0;
        step(2);
        set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        pulse_update();
        step(2);
        cfg_enable = 1'b1;
        wait_frame("sm_fs_seen", 10, st);
        capture_frame(len);
        check("sm_frame_len", len, 48);
        cnt_de = 0; cnt_hs = 0; cnt_vs = 0;
        for (int i = 0; i < 48; i++) begin
            cnt_de += int'(cap_de[i]);
            cnt_hs += int'(cap_hs[i]);
            cnt_vs += int'(cap_vs[i]);
        end
        check("sm_de_cnt", cnt_de, 12);
        check("sm_hs_cnt", cnt_hs, 12);
        check("sm_vs_cnt", cnt_vs, 8);
        check("sm_hs_h4", cap_hs[4], 0);
        check("sm_hs_h5", cap_hs[5], 1);
        check("sm_hs_h6", cap_hs[6], 1);
        check("sm_hs_h7", cap_hs[7], 0);
        check("sm_vs_l3_end", cap_vs[31], 0);
        check("sm_vs_l4_beg", cap_vs[32], 1);
        check("sm_vs_l4_end", cap_vs[39], 1);
        check("sm_vs_l5_beg", cap_vs[40], 0);
        for (int i = 0; i < 4; i++) check($sformatf("sm_pix_x%0d", i), cap_px[i], i);
        check("sm_pix_y_l2", cap_py[17], 2);
`ifdef HDMI_TIMING_TEST_PATTERN_EN
        check("tp_bar_p0", cap_rgb[0], 32'hFFFFFF);
        check("tp_bar_p1", cap_rgb[1], 32'h00FFFF);
        check("tp_bar_p2", cap_rgb[2], 32'hFF00FF);
        check("tp_bar_p3", cap_rgb[3], 32'h0000FF);
        check("tp_blank", cap_rgb[4], 0);
`endif

        // mid-frame update to h_active=6: current frame keeps length 8
        step(10);
        set_cfg(6, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        pulse_update();
        check("mid_pend_set", cfg_pending, 1);
        st = 0;
        while (!line_start && st < 20) begin step(1); st++; end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("mid_pend_hold%0d", k), cfg_pending, 1);
            measure_line(1'b1, len, de_n, hs_n, hs_first);
            check($sformatf("mid_old_len%0d", k), len, 8);
        end
        check("mid_new_fs", frame_start, 1);
        check("mid_pend_clr", cfg_pending, 0);
        measure_line(1'b1, len, de_n, hs_n, hs_first);
        check("mid_new_len", len, 10);
        check("mid_new_de", de_n, 6);

        // update coincident with last pixel (frame is 10x6=60 cycles)
        wait_frame("lp_fs_seen", 100, st);
        step(58);
        set_cfg(4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1);
        pulse_update();
        check("lp_pend_last", cfg_pending, 0);
        step(1);
        check("lp_fs", frame_start, 1);
        check("lp_pend_new", cfg_pending, 0);
        measure_line(1'b1, len, de_n, hs_n, hs_first);
        check("lp_new_len", len, 8);
        check("lp_new_de", de_n, 4);

        // drop enable mid-line for 3 cycles
        wait_frame("drop_fs_seen", 60, st);
        step(13);
        check("drop_pre_hs", hsync, 1);
        cfg_enable = 1'b0;
        step(1);
        check("drop_de", de, 0);
        check("drop_hs", hsync, 0);
        check("drop_vs", vsync, 0);
        step(2);
        cfg_enable = 1'b1;
        step(1);
        check("rest_no_fs", frame_start, 0);
        step(1);
        check("rest_fs", frame_start, 1);
        check("rest_ls", line_start, 1);
        check("rest_de", de, 1);
        check("rest_pix_x", pix_x, 0);

        // zero porches and zero sync
        cfg_enable = 1'b0;
        step(2);
        set_cfg(4, 0, 0, 0, 3, 1, 1, 1, 1'b1, 1'b1);
        pulse_update();
        step(2);
        cfg_enable = 1'b1;
        wait_frame("zr_fs_seen", 10, st);
        measure_line(1'b1, len, de_n, hs_n, hs_first);
        check("zr_line_len", len, 5);
        check("zr_de_cnt", de_n, 4);
        check("zr_hs_width", hs_n, 1);
        check("zr_hs_start", hs_first, 4);

        // reset mid-frame with an update pending restores defaults
        step(3);
        pulse_update();
        check("mrst_pend_set", cfg_pending, 1);
        ARESETN = 1'b0;
        step(1);
        check("mrst_pend", cfg_pending, 0);
        check("mrst_de", de, 0);
        check("mrst_hs", hsync, 0);
        check("mrst_vs", vsync, 0);
        check("mrst_ls", line_start, 0);
        check("mrst_pix_x", pix_x, 0);
        ARESETN = 1'b1;
        wait_frame("mrst_fs_seen", 10, st);
        measure_line(1'b1, len, de_n, hs_n, hs_first);
        check("mrst_line_len", len, 800);
        check("mrst_hs_width", hs_n, 96);
        check("mrst_hs_start", hs_first, 656);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
